// File: rtl/instr_fetch_unit.sv
// Front-end fetch stage: keeps the fetch PC, issues one memory request at a time, buffers bytes in a prefetch FIFO.
// Latency: ack in cycle N gives instr_valid in cycle N+1; at most one request every 2 cycles.
// Backpressure: a full FIFO (count == DEPTH) blocks new requests; a redirect flushes the FIFO and drops any in-flight return.
//
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   imem_req/addr         - memory request, held with a stable address until imem_ack
//   imem_ack/data         - memory completion; data valid in the ack cycle
//   instr_valid/ready     - show-ahead FIFO head toward the core
//   instruction/instr_pc  - head byte and its address (0 when instr_valid is low)
//   redirect/redirect_pc  - branch taken: reload fetch PC and flush
//   halt                  - stops new requests; in-flight request still completes
//   fifo_count            - current FIFO occupancy
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_ack,
    input  logic [7:0]               imem_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [7:0]               instruction,
    output logic [ADDR_W-1:0]        instr_pc,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     halt,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DISCARD
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  fetch_pc_q;
    logic [ADDR_W-1:0]  addr_q;

    logic [7:0]         mem_instr_q [DEPTH];
    logic [ADDR_W-1:0]  mem_pc_q    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic push;
    logic pop;
    logic start_req;

    // A return is only kept when it completes a live request and no redirect
    // is flushing the buffer in the same cycle.
    assign push = (state_q == ST_WAIT) && imem_ack && !redirect;
    assign pop  = instr_valid && instr_ready;

    // A redirect empties the FIFO this cycle, so space is guaranteed and the
    // count check is skipped.
    assign start_req = (state_q == ST_IDLE) && !halt &&
                       (redirect || (count_q < DEPTH_C));

    // Request FSM and fetch PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        state_q <= ST_WAIT;
                        // Fetch from the redirect target straight away when
                        // the redirect arrives in the launching cycle.
                        addr_q  <= redirect ? redirect_pc : fetch_pc_q;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        state_q <= ST_IDLE;
                    end else if (redirect) begin
                        // The request cannot be withdrawn: keep it up and
                        // throw away whatever comes back.
                        state_q <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (imem_ack) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (redirect) begin
                fetch_pc_q <= redirect_pc;
            end else if (push) begin
                fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
            end
        end
    end

    // FIFO pointer/count next-state; redirect wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= imem_data;
            mem_pc_q[wr_ptr_q]    <= addr_q;
        end
    end

    assign imem_req    = (state_q == ST_WAIT) || (state_q == ST_DISCARD);
    assign imem_addr   = addr_q;
    assign instr_valid = (count_q != '0);
    assign instruction = instr_valid ? mem_instr_q[rd_ptr_q] : 8'h00;
    assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q] : '0;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] instruction;
    logic [7:0] instr_pc;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       halt = 1'b0;
    logic [2:0] fifo_count;

    typedef struct packed {
        logic [7:0] instr;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   ack_delay = 0;
    int   wait_cnt = 0;
    int   n_req = 0;

    instr_fetch_unit #(
        .ADDR_W  (8),
        .DEPTH   (4),
        .RESET_PC(8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instruction(instruction),
        .instr_pc   (instr_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp_v);
        end
    endtask

    task automatic expect_entry(input logic [7:0] i, input logic [7:0] p);
        exp_q.push_back({i, p});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic h, input logic r, input int d);
        step();
        reset       = 1'b1;
        redirect    = 1'b0;
        halt        = h;
        instr_ready = r;
        ack_delay   = d;
        step();
        step();
        reset = 1'b0;
    endtask

    // Instruction memory: acks after ack_delay extra cycles, data = addr + 0x10.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (imem_req) begin
                if (wait_cnt == ack_delay) begin
                    imem_ack  = 1'b1;
                    imem_data = imem_addr + 8'h10;
                    wait_cnt  = 0;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: every accepted head is compared to the next expected entry.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_pop: got instr=%0h pc=%0h, required no entry", instruction, instr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_instr", 32'(instruction), 32'(mon_e.instr));
                chk("pop_pc", 32'(instr_pc), 32'(mon_e.pc));
            end
        end
    end

    initial begin
        #1 reset = 1'b1;
        step();
        step();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);

        // Streaming with zero-wait memory and a ready core.
        expect_entry(8'h10, 8'h00);
        expect_entry(8'h11, 8'h01);
        expect_entry(8'h12, 8'h02);
        expect_entry(8'h13, 8'h03);
        instr_ready = 1'b1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_req", 32'(imem_req), 32'd1);
            chk("t1_addr", 32'(imem_addr), k);
            step();
            chk("t1_gap_req", 32'(imem_req), 32'd0);
            chk("t1_valid", 32'(instr_valid), 32'd1);
        end
        halt = 1'b1;
        repeat (3) step();
        chk("t1_count", 32'(fifo_count), 32'd0);
        chk("t1_drained", exp_q.size(), 0);

        // Core stalled: FIFO fills to 4, one pop allows one more request.
        expect_entry(8'h10, 8'h00);
        expect_entry(8'h11, 8'h01);
        expect_entry(8'h12, 8'h02);
        expect_entry(8'h13, 8'h03);
        do_reset(1'b0, 1'b0, 0);
        n_req = 0;
        repeat (12) begin
            step();
            if (imem_req && imem_ack) n_req++;
        end
        chk("t2_req_count", n_req, 4);
        chk("t2_full_count", 32'(fifo_count), 32'd4);
        chk("t2_full_req", 32'(imem_req), 32'd0);
        chk("t2_head_instr", 32'(instruction), 32'h10);
        chk("t2_head_pc", 32'(instr_pc), 32'h00);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t2_count_pop", 32'(fifo_count), 32'd3);
        chk("t2_req_pop", 32'(imem_req), 32'd0);
        expect_entry(8'h14, 8'h04);
        step();
        chk("t2_refill_req", 32'(imem_req), 32'd1);
        chk("t2_refill_addr", 32'(imem_addr), 32'h04);
        halt = 1'b1;
        instr_ready = 1'b1;
        repeat (8) step();
        chk("t2_count", 32'(fifo_count), 32'd0);
        chk("t2_drained", exp_q.size(), 0);

        // Redirect during WAIT with a slow memory: request held, data dropped.
        do_reset(1'b0, 1'b0, 3);
        step();
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", 32'(imem_addr), 32'h00);
        chk("t3_noack", 32'(imem_ack), 32'd0);
        redirect = 1'b1;
        redirect_pc = 8'h40;
        step();
        redirect = 1'b0;
        chk("t3_hold_req", 32'(imem_req), 32'd1);
        chk("t3_hold_addr", 32'(imem_addr), 32'h00);
        step();
        chk("t3_hold_addr2", 32'(imem_addr), 32'h00);
        step();
        chk("t3_late_req", 32'(imem_req), 32'd1);
        chk("t3_late_ack", 32'(imem_ack), 32'd1);
        step();
        chk("t3_drop_req", 32'(imem_req), 32'd0);
        chk("t3_drop_count", 32'(fifo_count), 32'd0);
        chk("t3_drop_valid", 32'(instr_valid), 32'd0);
        ack_delay = 0;
        expect_entry(8'h50, 8'h40);
        step();
        chk("t3_new_req", 32'(imem_req), 32'd1);
        chk("t3_new_addr", 32'(imem_addr), 32'h40);
        halt = 1'b1;
        instr_ready = 1'b1;
        repeat (4) step();
        chk("t3_drained", exp_q.size(), 0);

        // Redirect in the same cycle as the ack.
        do_reset(1'b0, 1'b0, 0);
        step();
        chk("t4_req", 32'(imem_req), 32'd1);
        chk("t4_ack", 32'(imem_ack), 32'd1);
        redirect = 1'b1;
        redirect_pc = 8'h80;
        step();
        redirect = 1'b0;
        chk("t4_valid", 32'(instr_valid), 32'd0);
        chk("t4_count", 32'(fifo_count), 32'd0);
        chk("t4_gap_req", 32'(imem_req), 32'd0);
        expect_entry(8'h90, 8'h80);
        step();
        chk("t4_new_req", 32'(imem_req), 32'd1);
        chk("t4_new_addr", 32'(imem_addr), 32'h80);
        halt = 1'b1;
        instr_ready = 1'b1;
        repeat (4) step();
        chk("t4_drained", exp_q.size(), 0);

        // Fetch PC wrap from 0xFF to 0x00.
        do_reset(1'b1, 1'b0, 0);
        redirect = 1'b1;
        redirect_pc = 8'hFF;
        step();
        redirect = 1'b0;
        halt = 1'b0;
        chk("t5_halted_req", 32'(imem_req), 32'd0);
        step();
        chk("t5_req", 32'(imem_req), 32'd1);
        chk("t5_addr_ff", 32'(imem_addr), 32'hFF);
        expect_entry(8'h0F, 8'hFF);
        step();
        chk("t5_valid", 32'(instr_valid), 32'd1);
        chk("t5_head_pc", 32'(instr_pc), 32'hFF);
        step();
        chk("t5_wrap_req", 32'(imem_req), 32'd1);
        chk("t5_wrap_addr", 32'(imem_addr), 32'h00);
        expect_entry(8'h10, 8'h00);
        halt = 1'b1;
        step();
        instr_ready = 1'b1;
        repeat (4) step();
        chk("t5_drained", exp_q.size(), 0);

        // Halt raised mid-request: request completes, then no more until released.
        do_reset(1'b0, 1'b1, 2);
        step();
        chk("t6_req", 32'(imem_req), 32'd1);
        chk("t6_addr", 32'(imem_addr), 32'h00);
        halt = 1'b1;
        expect_entry(8'h10, 8'h00);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_halted_req", 32'(imem_req), 32'd0);
        end
        halt = 1'b0;
        step();
        chk("t6_resume_req", 32'(imem_req), 32'd1);
        chk("t6_resume_addr", 32'(imem_addr), 32'h01);
        halt = 1'b1;
        expect_entry(8'h11, 8'h01);
        repeat (6) step();
        chk("t6_count", 32'(fifo_count), 32'd0);
        chk("t6_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end fetch stage that sits directly upstream of the CPU core. It drives the core's 8-bit instruction input. It keeps the fetch PC, issues single-outstanding requests to instruction memory over a req/ack handshake, and buffers returned bytes in a small prefetch FIFO. The FIFO is presented to the core through a valid/ready interface. A branch redirect flushes the FIFO and drops any in-flight return.

Parameters:
ADDR_W, 8, width of fetch PC and instruction-memory address
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, fetch PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
imem_req  output  1  request to instruction memory; held until imem_ack
imem_addr  output  ADDR_W  request address; stable while imem_req high
imem_ack  input  1  memory completion; imem_data valid in the same cycle
imem_data  input  8  returned instruction byte
instr_valid  output  1  FIFO head valid toward core
instr_ready  input  1  core accepts head this cycle
instruction  output  8  FIFO head instruction; 0 when instr_valid low
instr_pc  output  ADDR_W  address of FIFO head; 0 when instr_valid low
redirect  input  1  branch taken; load redirect_pc and flush
redirect_pc  input  ADDR_W  new fetch address
halt  input  1  suppress new requests; in-flight request completes
fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async): state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr pointers=0. All outputs are 0: imem_req, imem_addr, instr_valid, instruction, instr_pc, fifo_count.
- Each FIFO entry stores {instruction, pc}. The FIFO is show-ahead. instr_valid = (count != 0). A pop occurs when instr_valid && instr_ready.
- The FSM has three states, and imem_req = (state==WAIT || state==DISCARD).
- IDLE:
  - Moves to WAIT when !redirect && !halt && count < DEPTH.
  - Moves to WAIT when redirect && !halt. Count becomes 0 after the flush, so space is available.
  - imem_addr latches fetch_pc on entry to WAIT.
- WAIT:
  - On imem_ack && !redirect: push {imem_data, imem_addr}, fetch_pc <= fetch_pc+1 (wraps modulo 2^ADDR_W), go IDLE.
  - On imem_ack && redirect: drop the data, go IDLE.
  - On !imem_ack && redirect: go DISCARD. imem_req and imem_addr stay unchanged, because the protocol forbids withdrawing a request.
- DISCARD: on imem_ack, drop the data and go IDLE. A further redirect here only updates fetch_pc.
- Throughput: at most one request per 2 cycles (the IDLE cycle separates requests). The minimum latency is request in cycle N, ack in cycle N, instr_valid in cycle N+1.
- Single outstanding request. The request is issued only when count < DEPTH, so a push never overflows. Simultaneous push and pop leaves count unchanged.
- Redirect (highest priority, any state):
  - fetch_pc <= redirect_pc.
  - count, rd_ptr and wr_ptr are cleared, so instr_valid is low the next cycle.
  - A pop in the same cycle counts as consumed by the core. A push in the same cycle is discarded.
- halt: blocks IDLE->WAIT only. WAIT and DISCARD complete normally. The FIFO still drains to the core.
- Reset asserted mid-request: everything clears immediately and imem_req drops. The memory model must tolerate the abandoned request.
- instruction and instr_pc are gated to 0 whenever count==0.

Test Plan:
- Reset release, ack same cycle, memory returns 8'h10,8'h11,... with instr_ready=1 -> imem_addr 0,1,2,3 on every other cycle; instruction 8'h10 appears with instr_pc=0 one cycle after the first ack.
- instr_ready=0, DEPTH=4 -> exactly 4 requests. imem_req stays low after that and fifo_count=4. Raising ready for one cycle -> pop 1, then a new request to addr 4.
- Redirect to 8'h40 during WAIT with ack delayed 3 cycles -> imem_req stays high at the old address until ack, that data is dropped, fifo_count=0, and the next request has imem_addr=8'h40.
- Redirect to 8'h80 in the same cycle as imem_ack -> returned byte is not pushed, instr_valid is low the next cycle, and the next request goes to 8'h80.
- fetch_pc=8'hFF with a successful fetch -> the next request goes to 8'h00, and instr_pc of the pushed entry = 8'hFF.
- halt=1 asserted while in WAIT -> that request completes and is pushed, then no further imem_req. Releasing halt -> the request resumes at the next address.
